// File: rtl/seq_bench_pkg.sv
// seq_bench_pkg: shared defaults and the scan controller state type for seq_scan_bench.
`default_nettype none

package seq_bench_pkg;

   localparam int NIN_DEF    = 36;
   localparam int NOUT_DEF   = 23;
   localparam int NSTATE_DEF = 19;

   typedef enum logic [0:0] {
      FUNC  = 1'b0,
      SHIFT = 1'b1
   } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/scan_ctrl.sv
// scan_ctrl: FUNC/SHIFT controller, modulo-NSTATE shift counter and full-chain pulse.
`default_nettype none

module scan_ctrl
   import seq_bench_pkg::*;
#(
   parameter int NSTATE = NSTATE_DEF,
   parameter int CW     = $clog2(NSTATE)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          se_i,
   output logic [CW-1:0] cnt_o,
   output logic          done_o
);

   scan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          wrap;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FUNC;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FUNC:    if (se_i)  state_d = SHIFT;
         SHIFT:   if (!se_i) state_d = FUNC;
         default: state_d = FUNC;
      endcase
   end

   // A wrap needs at least one earlier shifting edge, so it can only occur in SHIFT.
   always_comb begin
      wrap   = (cnt_q == CW'(NSTATE - 1));
      cnt_d  = '0;
      done_d = 1'b0;
      if (se_i) begin
         cnt_d  = wrap ? '0 : cnt_q + CW'(1);
         done_d = (state_q == SHIFT) && wrap;
      end
   end

   assign cnt_o  = cnt_q;
   assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/seq_scan_bench.sv
// seq_scan_bench: scannable sequential benchmark; define SCAN_OBFUSCATE_EN to XOR the
// scan-out stream with KEY[CNT] while shifting.
`default_nettype none

module seq_scan_bench
   import seq_bench_pkg::*;
#(
   parameter int NIN    = NIN_DEF,
   parameter int NOUT   = NOUT_DEF,
   parameter int NSTATE = NSTATE_DEF
) (
   input  logic              CK,
   input  logic              RN,
   input  logic [NIN-1:0]    IN,
   input  logic              SE,
   input  logic              SI,
   input  logic [NSTATE-1:0] KEY,
   output logic [NOUT-1:0]   OUT,
   output logic              SO,
   output logic              SHIFT_DONE
);

   localparam int CW = $clog2(NSTATE);

   logic [NSTATE-1:0] s_q, s_d;
   logic [CW-1:0]     cnt;
   logic              unused_in;

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) s_q <= '0;
      else     s_q <= s_d;
   end

   for (genvar i = 0; i < NSTATE; i++) begin : g_state
      localparam int PREV = (i + NSTATE - 1) % NSTATE;
      localparam int NEXT = (i + 1) % NSTATE;
      if (i == 0) begin : g_head
         assign s_d[i] = SE ? SI
                            : s_q[PREV] ^ (IN[i % NIN] & ~s_q[NEXT]);
      end else begin : g_body
         assign s_d[i] = SE ? s_q[PREV]
                            : s_q[PREV] ^ (IN[i % NIN] & ~s_q[NEXT]);
      end
   end

   for (genvar j = 0; j < NOUT; j++) begin : g_out
      assign OUT[j] = s_q[j % NSTATE] ^ IN[j % NIN];
   end

   // Not every IN bit reaches the logic for all parameter sets.
   assign unused_in = ^IN;

   scan_ctrl #(
      .NSTATE (NSTATE),
      .CW     (CW)
   ) u_ctrl (
      .clk_i  (CK),
      .rst_ni (RN),
      .se_i   (SE),
      .cnt_o  (cnt),
      .done_o (SHIFT_DONE)
   );

`ifdef SCAN_OBFUSCATE_EN
   assign SO = SE ? (s_q[NSTATE-1] ^ KEY[cnt]) : s_q[NSTATE-1];
`else
   logic unused_key;
   assign unused_key = ^{KEY, cnt};
   assign SO         = s_q[NSTATE-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_bench.sv
// tb_seq_scan_bench: directed, table-driven checks of seq_scan_bench at default parameters.
`default_nettype none
`timescale 1ns/1ps

module tb_seq_scan_bench;

   localparam int NI = 36;
   localparam int NO = 23;
   localparam int NS = 19;

   logic          CK = 1'b0;
   logic          RN = 1'b0;
   logic          SE = 1'b0;
   logic          SI = 1'b0;
   logic [NI-1:0] IN = '0;
   logic [NS-1:0] KEY = '0;
   logic [NO-1:0] OUT;
   logic          SO;
   logic          SHIFT_DONE;

   int checks = 0;
   int errors = 0;

   seq_scan_bench #(.NIN(NI), .NOUT(NO), .NSTATE(NS)) dut (
      .CK         (CK),
      .RN         (RN),
      .IN         (IN),
      .SE         (SE),
      .SI         (SI),
      .KEY        (KEY),
      .OUT        (OUT),
      .SO         (SO),
      .SHIFT_DONE (SHIFT_DONE)
   );

   always #5 CK = ~CK;

   typedef struct {
      logic [NS-1:0] s0;
      logic [NI-1:0] in;
      logic [NS-1:0] s1;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [NO-1:0] exp_out(input logic [NS-1:0] s, input logic [NI-1:0] in);
      logic [NO-1:0] o;
      for (int j = 0; j < NO; j++) o[j] = s[j % NS] ^ in[j % NI];
      return o;
   endfunction

   function automatic logic exp_so_key(input logic [NS-1:0] key, input int c);
`ifdef SCAN_OBFUSCATE_EN
      return key[c];
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic check_s(input string name, input logic [NS-1:0] s);
      chk({name, "_out"}, 64'(OUT), 64'(exp_out(s, IN)));
      chk({name, "_so"}, 64'(SO), 64'(s[NS-1]));
   endtask

   task automatic do_reset();
      RN = 1'b0; SE = 1'b0; SI = 1'b0; IN = '0; KEY = '0;
      tick();
      RN = 1'b1;
      #1;
   endtask

   task automatic load(input logic [NS-1:0] s);
      SE = 1'b1;
      for (int k = NS - 1; k >= 0; k--) begin
         SI = s[k];
         tick();
      end
      SE = 1'b0;
      SI = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{19'h00000, 36'hF_FFFF_FFFF, 19'h7FFFF};
      vecs[1] = '{19'h7FFFF, 36'hF_FFFF_FFFF, 19'h7FFFF};
      vecs[2] = '{19'h7FFFF, 36'h0_0000_0000, 19'h7FFFF};
      vecs[3] = '{19'h00000, 36'h0_0000_0000, 19'h00000};
      vecs[4] = '{19'h00001, 36'h0_0000_0000, 19'h00002};
      vecs[5] = '{19'h40000, 36'h0_0000_0000, 19'h00001};
      vecs[6] = '{19'h00001, 36'hF_FFFF_FFFF, 19'h3FFFD};
      vecs[7] = '{19'h00000, 36'h0_0000_0005, 19'h00005};
      vecs[8] = '{19'h2AAAA, 36'hF_FFFF_FFFF, 19'h3FFFE};

      // Reset state
      RN = 1'b0;
      #2;
      chk("rst_out", 64'(OUT), 64'h0);
      chk("rst_so", 64'(SO), 64'h0);
      chk("rst_done", 64'(SHIFT_DONE), 64'h0);
      IN = 36'hA_5A5A_5A5A;
      #1;
      chk("rst_out_in", 64'(OUT), 64'(exp_out('0, IN)));
      do_reset();

      // Functional next-state table
      for (int v = 0; v < 9; v++) begin
         do_reset();
         load(vecs[v].s0);
         IN = vecs[v].in;
         #1;
         check_s($sformatf("vec%0d_pre", v), vecs[v].s0);
         tick();
         check_s($sformatf("vec%0d_post", v), vecs[v].s1);
      end

      // All-ones input from reset, then hold
      do_reset();
      IN = '1;
      #1;
      chk("ones_out0", 64'(OUT), 64'(exp_out('0, IN)));
      tick();
      chk("ones_out1", 64'(OUT), 64'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_s($sformatf("ones_hold%0d", k), '1);
      end

      // Two full chains of ones
      do_reset();
      SE = 1'b1; SI = 1'b1;
      for (int k = 1; k <= 38; k++) begin
         tick();
         chk($sformatf("chain_done%0d", k), 64'(SHIFT_DONE), 64'((k == 19) || (k == 38)));
         if (k == 19) check_s("chain_full", '1);
      end
      SE = 1'b0;
      tick();
      chk("chain_done_after", 64'(SHIFT_DONE), 64'h0);

      // Shift aborted mid-chain by SE drop
      do_reset();
      SE = 1'b1; SI = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("part_done%0d", k), 64'(SHIFT_DONE), 64'h0);
      end
      SE = 1'b0; SI = 1'b0;
      tick();
      check_s("part_func", 19'h000FE);
      chk("part_done_func", 64'(SHIFT_DONE), 64'h0);
      SE = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk($sformatf("part2_done%0d", k), 64'(SHIFT_DONE), 64'(k == 19));
      end
      SE = 1'b0;

      // Scan-out obfuscation stream
      do_reset();
      KEY = 19'h5_5555;
      SE = 1'b1; SI = 1'b0;
      #1;
      chk("obf_so0", 64'(SO), 64'(exp_so_key(KEY, 0)));
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk($sformatf("obf_so%0d", k), 64'(SO), 64'(exp_so_key(KEY, k % NS)));
      end
      SE = 1'b0;
      #1;
      chk("obf_so_func", 64'(SO), 64'h0);
      KEY = '0;

      // Reset during a shift
      do_reset();
      SE = 1'b1; SI = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("mid_so_pre", 64'(OUT[9:0]), 64'h3FF);
      RN = 1'b0; SE = 1'b0;
      #1;
      chk("mid_rst_out", 64'(OUT), 64'(exp_out('0, IN)));
      chk("mid_rst_so", 64'(SO), 64'h0);
      chk("mid_rst_done", 64'(SHIFT_DONE), 64'h0);
      SE = 1'b1;
      tick();
      SE = 1'b0;
      #1;
      chk("mid_rst_hold", 64'(OUT), 64'(exp_out('0, IN)));
      RN = 1'b1;
      SE = 1'b1; SI = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk($sformatf("mid_new_done%0d", k), 64'(SHIFT_DONE), 64'(k == 19));
      end
      SE = 1'b0; SI = 1'b0;
      #1;
      check_s("mid_new_full", '1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
